// File: rtl/video_pkg.sv
// Shared definitions for the video_controller timeline logic.
//   state_e      : sequencer FSM states
//   layer_en_t   : per-scene layer enable bundle (grids/sprite/text)
//   layer_table  : scene -> layer enable decode
//   DEF_*        : default sprite bounce bounds, reset position and text base
package video_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FADE_IN,
    ST_RUN,
    ST_FADE_OUT,
    ST_RECONF
  } state_e;

  localparam logic [1:0] SCENE_FIRST = 2'd0;
  localparam logic [1:0] SCENE_LAST  = 2'd3;

  localparam logic [3:0] FADE_BLACK  = 4'd15;
  localparam logic [3:0] FADE_IN_END = 4'd1;   // last fade value before RUN
  localparam logic [3:0] FADE_OUT_END = 4'd14; // last fade value before scene change

  localparam int unsigned DEF_PX_MIN   = 180;
  localparam int unsigned DEF_PX_MAX   = 1300;
  localparam int unsigned DEF_LN_MIN   = 40;
  localparam int unsigned DEF_LN_MAX   = 670;
  localparam int unsigned DEF_SPR_INIT = 300;

  localparam logic [11:0] TEXT_PX_BASE = 12'd160;

  typedef struct packed {
    logic grids;
    logic sprite;
    logic text;
  } layer_en_t;

  function automatic layer_en_t layer_table(input logic [1:0] scene);
    layer_en_t le;
    le = '0;
    case (scene)
      2'd0: le.grids = 1'b1;
      2'd1: begin
        le.grids  = 1'b1;
        le.sprite = 1'b1;
      end
      2'd2: begin
        le.grids  = 1'b1;
        le.sprite = 1'b1;
        le.text   = 1'b1;
      end
      default: le.text = 1'b1;
    endcase
    return le;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One sprite axis bouncing between MIN and MAX.
//   clk   in  : clock, posedge
//   rst_n in  : asynchronous active-low reset (pos=INIT, direction +1)
//   step  in  : advance one unit in the current direction
//   pos   out : current position, 12 bit
// Direction flips when the new position lands on either bound, so the bound
// itself is visited exactly once per bounce.
module bounce_axis
  import video_pkg::*;
#(
  parameter int unsigned MIN  = DEF_PX_MIN,
  parameter int unsigned MAX  = DEF_PX_MAX,
  parameter int unsigned INIT = DEF_SPR_INIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [11:0] pos
);

  localparam logic [11:0] MIN_C  = 12'(MIN);
  localparam logic [11:0] MAX_C  = 12'(MAX);
  localparam logic [11:0] INIT_C = 12'(INIT);

  logic [11:0] pos_q, pos_d, next_pos;
  logic        dir_q, dir_d;

  always_comb begin
    next_pos = dir_q ? pos_q + 12'd1 : pos_q - 12'd1;
    pos_d    = pos_q;
    dir_d    = dir_q;
    if (step) begin
      pos_d = next_pos;
      if (next_pos == MAX_C || next_pos == MIN_C) begin
        dir_d = ~dir_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= INIT_C;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/scene_sequencer.sv
// Demo timeline controller beside the mixer: counts frames, steps four scenes
// with fade in/out, decodes layer enables, bounces the sprite, scrolls text and
// requests FPGA reconfiguration after the last scene.
//   clk, rst_n          : pixel clock / asynchronous active-low reset
//   frame_end           : one-cycle end-of-frame pulse (the frame tick)
//   halt                : freeze, frame_end ignored while high
//   skip                : pulse, end the current RUN scene early
//   reconf_ack          : reconfiguration accepted
//   reconf_req          : high while waiting in RECONF
//   frames [11:0]       : free-running frame count
//   scene [1:0], fade [3:0] : current scene, attenuation (15 = black)
//   grids_en/sprite_en/text_en : layer enables
//   spritepx/spriteln [11:0]   : sprite position
//   text_pixel_offset [11:0], text_offset [7:0] : text scroll
module scene_sequencer
  import video_pkg::*;
#(
  parameter int unsigned SCENE_FRAMES = 512,
  parameter int unsigned PX_MIN       = DEF_PX_MIN,
  parameter int unsigned PX_MAX       = DEF_PX_MAX,
  parameter int unsigned LN_MIN       = DEF_LN_MIN,
  parameter int unsigned LN_MAX       = DEF_LN_MAX,
  parameter int unsigned SPR_INIT     = DEF_SPR_INIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_end,
  input  logic        halt,
  input  logic        skip,
  input  logic        reconf_ack,
  output logic        reconf_req,
  output logic [11:0] frames,
  output logic [1:0]  scene,
  output logic [3:0]  fade,
  output logic        grids_en,
  output logic        sprite_en,
  output logic        text_en,
  output logic [11:0] spritepx,
  output logic [11:0] spriteln,
  output logic [11:0] text_pixel_offset,
  output logic [7:0]  text_offset
);

  localparam int unsigned CNT_W = (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCENE_FRAMES - 1);

  state_e           state_q, state_d;
  logic [1:0]       scene_q, scene_d;
  logic [3:0]       fade_q, fade_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             skip_q, skip_d;
  logic             req_q, req_d;
  logic [11:0]      frames_q, frames_d, frames_next;
  logic [11:0]      tpo_q, tpo_d;
  logic [7:0]       toff_q, toff_d;
  logic             tick;
  layer_en_t        layer;

  assign tick        = frame_end & ~halt;
  assign frames_next = frames_q + 12'd1;

  always_comb begin
    state_d  = state_q;
    scene_d  = scene_q;
    fade_d   = fade_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    frames_d = frames_q;
    tpo_d    = tpo_q;
    toff_d   = toff_q;
    // skip is only remembered while in RUN; any other state drops it
    skip_d   = (state_q == ST_RUN) ? (skip_q | skip) : 1'b0;

    if (tick) begin
      frames_d = frames_next;
      tpo_d    = TEXT_PX_BASE - {5'd0, frames_next[3:0], 3'd0};
      toff_d   = frames_next[11:4];
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (tick) begin
          fade_d = fade_q - 4'd1;
          if (fade_q == FADE_IN_END) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (tick) begin
          cnt_d = cnt_q + 1'b1;
          // a skip arriving on the tick itself ends the scene on that tick
          if (cnt_q == CNT_LAST || skip_q || skip) begin
            state_d = ST_FADE_OUT;
            skip_d  = 1'b0;
          end
        end
      end
      ST_FADE_OUT: begin
        if (tick) begin
          fade_d = fade_q + 4'd1;
          if (fade_q == FADE_OUT_END) begin
            if (scene_q == SCENE_LAST) begin
              state_d = ST_RECONF;
              req_d   = 1'b1;
            end else begin
              state_d = ST_FADE_IN;
              scene_d = scene_q + 2'd1;
            end
          end
        end
      end
      ST_RECONF: begin
        req_d = 1'b1;
        if (reconf_ack) begin
          state_d = ST_FADE_IN;
          scene_d = SCENE_FIRST;
          fade_d  = FADE_BLACK;
          req_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      scene_q  <= SCENE_FIRST;
      fade_q   <= FADE_BLACK;
      cnt_q    <= '0;
      skip_q   <= 1'b0;
      req_q    <= 1'b0;
      frames_q <= '0;
      tpo_q    <= TEXT_PX_BASE;
      toff_q   <= '0;
    end else begin
      state_q  <= state_d;
      scene_q  <= scene_d;
      fade_q   <= fade_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      req_q    <= req_d;
      frames_q <= frames_d;
      tpo_q    <= tpo_d;
      toff_q   <= toff_d;
    end
  end

  always_comb begin
    layer = '0;
    if (state_q == ST_FADE_IN || state_q == ST_RUN || state_q == ST_FADE_OUT) begin
      layer = layer_table(scene_q);
    end
  end

  bounce_axis #(
    .MIN (PX_MIN),
    .MAX (PX_MAX),
    .INIT(SPR_INIT)
  ) u_axis_px (
    .clk  (clk),
    .rst_n(rst_n),
    .step (tick & layer.sprite),
    .pos  (spritepx)
  );

  bounce_axis #(
    .MIN (LN_MIN),
    .MAX (LN_MAX),
    .INIT(SPR_INIT)
  ) u_axis_ln (
    .clk  (clk),
    .rst_n(rst_n),
    .step (tick & layer.sprite),
    .pos  (spriteln)
  );

  assign reconf_req        = req_q;
  assign frames            = frames_q;
  assign scene             = scene_q;
  assign fade              = fade_q;
  assign grids_en          = layer.grids;
  assign sprite_en         = layer.sprite;
  assign text_en           = layer.text;
  assign text_pixel_offset = tpo_q;
  assign text_offset       = toff_q;

endmodule
